midi_router_matrix: RTL

MIDI_ROUTER_MATRIX -- requirements
Module: midi_router_matrix

---
 rtl/midi_router_matrix_if.sv | 31 +++
 rtl/midi_router_matrix.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/midi_router_matrix_if.sv
// rtl/midi_router_matrix_if.sv - MIDI lines and SPI register port bundle; act lines exist only with ACTIVITY_LED_EN
interface midi_router_matrix_if #(
  parameter int NUM_IN  = 4,
  parameter int NUM_OUT = 4
);
  logic [NUM_IN-1:0]  midi_in;
  logic [NUM_OUT-1:0] midi_out;
  logic               spi_clk;
  logic               spi_ss;
  logic               spi_mosi;
  logic               spi_miso;
`ifdef ACTIVITY_LED_EN
  logic [NUM_IN-1:0]  act;
`endif

  modport master (
    output midi_in, spi_clk, spi_ss, spi_mosi,
    input  midi_out, spi_miso
`ifdef ACTIVITY_LED_EN
    , input act
`endif
  );

  modport slave (
    input  midi_in, spi_clk, spi_ss, spi_mosi,
    output midi_out, spi_miso
`ifdef ACTIVITY_LED_EN
    , output act
`endif
  );
endinterface

// File: rtl/midi_router_matrix.sv
// rtl/midi_router_matrix.sv - SPI-configured MIDI routing matrix with idle-deferred route switching; ACTIVITY_LED_EN adds act stretchers
module midi_router_matrix #(
  parameter int NUM_IN      = 4,
  parameter int NUM_OUT     = 4,
  parameter int IDLE_CYCLES = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  midi_router_matrix_if.slave bus
);
  localparam int            CW       = $clog2(IDLE_CYCLES + 1);
  localparam logic [CW-1:0] IDLE_MAX = CW'(IDLE_CYCLES);
  localparam logic [3:0]    IN_LIM   = 4'(NUM_IN);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} spi_state_t;

  logic [NUM_IN-1:0]  in_m, in_s;
  logic               sclk_m, sclk_s, sclk_q;
  logic               ss_m, ss_s, ss_q;
  logic               mosi_m, mosi_s;
  logic [1:0]         settle;
  logic               sclk_rise, sclk_fall, ss_fall;

  spi_state_t         state;
  logic [3:0]         bit_cnt;
  logic [14:0]        shift;
  logic [7:0]         tx;
  logic               miso;
  logic [7:0]         hdr_next;
  logic [7:0]         rd_val;
  logic               wr_stb;
  logic [6:0]         wr_addr;
  logic               wr_en;
  logic [2:0]         wr_src;

  logic               pend_en  [NUM_OUT];
  logic [2:0]         pend_src [NUM_OUT];
  logic               act_en   [NUM_OUT];
  logic [2:0]         act_src  [NUM_OUT];
  logic [CW-1:0]      idle_cnt [NUM_OUT];
  logic [NUM_OUT-1:0] sel;
  logic [NUM_OUT-1:0] out_q;

  // Two-flop synchronizers, edge-detect history, and a settle count that masks the synchronizer flush after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_m   <= '1;
      in_s   <= '1;
      sclk_m <= 1'b0;
      sclk_s <= 1'b0;
      sclk_q <= 1'b0;
      ss_m   <= 1'b1;
      ss_s   <= 1'b1;
      ss_q   <= 1'b1;
      mosi_m <= 1'b1;
      mosi_s <= 1'b1;
      settle <= 2'd0;
    end else begin
      in_m   <= bus.midi_in;
      in_s   <= in_m;
      sclk_m <= bus.spi_clk;
      sclk_s <= sclk_m;
      sclk_q <= sclk_s;
      ss_m   <= bus.spi_ss;
      ss_s   <= ss_m;
      ss_q   <= ss_s;
      mosi_m <= bus.spi_mosi;
      mosi_s <= mosi_m;
      if (settle != 2'd3) settle <= settle + 2'd1;
    end
  end

  // A select already low when reset releases must not look like a frame start
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign ss_fall   = (settle == 2'd3) & ss_q & ~ss_s;
  assign hdr_next  = {shift[6:0], mosi_s};

  // Pending-route readback for the address completing on the 8th bit
  always_comb begin
    rd_val = 8'h00;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (hdr_next[6:0] == 7'(k)) rd_val = {pend_en[k], 4'b0000, pend_src[k]};
    end
  end

  // SPI mode-0 slave frame FSM: shift on rising sclk, drive miso on falling sclk, commit on bit 16
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      bit_cnt <= 4'd0;
      shift   <= '0;
      tx      <= 8'h00;
      miso    <= 1'b0;
      wr_stb  <= 1'b0;
      wr_addr <= 7'd0;
      wr_en   <= 1'b0;
      wr_src  <= 3'd0;
    end else begin
      wr_stb <= 1'b0;
      case (state)
        ST_IDLE: begin
          bit_cnt <= 4'd0;
          miso    <= 1'b0;
          if (ss_fall) state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (ss_s) begin
            state <= ST_IDLE;
            miso  <= 1'b0;
          end else if (sclk_rise) begin
            shift   <= {shift[13:0], mosi_s};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) tx <= hdr_next[7] ? 8'h00 : rd_val;
            if (bit_cnt == 4'd15) begin
              wr_stb  <= shift[14];
              wr_addr <= shift[13:7];
              wr_en   <= shift[6];
              wr_src  <= {shift[1:0], mosi_s};
              state   <= ST_DONE;
            end
          end else if (sclk_fall) begin
            // bit_cnt 8..15 means the data byte is in progress
            if (bit_cnt[3]) begin
              miso <= tx[7];
              tx   <= {tx[6:0], 1'b0};
            end else begin
              miso <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          miso <= 1'b0;
          if (ss_s) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Source selection per output from the active route
  always_comb begin
    sel = '1;
    for (int k = 0; k < NUM_OUT; k++) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (act_src[k] == 3'(i)) sel[k] = in_s[i];
      end
    end
  end

  // Pending/active routes, idle counters, and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_OUT; k++) begin
        pend_en[k]  <= 1'b0;
        pend_src[k] <= 3'd0;
        act_en[k]   <= 1'b0;
        act_src[k]  <= 3'd0;
        idle_cnt[k] <= '0;
      end
      out_q <= '1;
    end else begin
      for (int k = 0; k < NUM_OUT; k++) begin
        if (wr_stb && (wr_addr == 7'(k)) && ({1'b0, wr_src} < IN_LIM)) begin
          pend_en[k]  <= wr_en;
          pend_src[k] <= wr_src;
        end
        if (!out_q[k]) idle_cnt[k] <= '0;
        else if (idle_cnt[k] != IDLE_MAX) idle_cnt[k] <= idle_cnt[k] + CW'(1);
        // Switching only after a full idle run keeps a byte in flight from being cut
        if (idle_cnt[k] == IDLE_MAX) begin
          act_en[k]  <= pend_en[k];
          act_src[k] <= pend_src[k];
        end
        out_q[k] <= act_en[k] ? sel[k] : 1'b1;
      end
    end
  end

  assign bus.midi_out = out_q;
  assign bus.spi_miso = miso;

`ifdef ACTIVITY_LED_EN
  logic [NUM_IN-1:0] in_q;
  logic [15:0]       stretch [NUM_IN];
  logic [NUM_IN-1:0] act_q;

  // Per-input pulse stretcher: 2^16 cycles high after each start-bit falling edge, retriggerable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q  <= '1;
      act_q <= '0;
      for (int i = 0; i < NUM_IN; i++) stretch[i] <= 16'd0;
    end else begin
      in_q <= in_s;
      for (int i = 0; i < NUM_IN; i++) begin
        if (in_q[i] && !in_s[i]) begin
          stretch[i] <= 16'hFFFF;
          act_q[i]   <= 1'b1;
        end else if (stretch[i] != 16'd0) begin
          stretch[i] <= stretch[i] - 16'd1;
        end else begin
          act_q[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.act = act_q;
`endif
endmodule
